// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel state
// encoding, a debug view of all four channel states, and the default
// timing constants (in clk cycles).
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Observation of every channel FSM, one field per button.
  typedef struct packed {
    btn_state_e mode;
    btn_state_e set;
    btn_state_e op1;
    btn_state_e op2;
  } btn_dbg_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM with an
// equality-compared counter, and an optional auto-repeat hold counter
// that only exists when REPEAT_EN is set.
//
// Handshake: none. pulse_o is a single-cycle event, level_o is the
// debounced level; both are registered. REPEAT_DELAY and REPEAT_PERIOD
// must be at least 1 when REPEAT_EN is set.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       raw_i,
  output logic       pulse_o,
  output logic       level_o,
  output btn_state_e state_o
);

  // Counter holds values up to and including DEBOUNCE_CYCLES.
  localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]    DB_LIMIT = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  logic          s;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          level_q, level_d;
  logic          rep_fire;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;

  // Debounce FSM state, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // Next-state logic: a bounce during either wait state restarts the window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LIMIT) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        pulse_d = rep_fire;
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          // Bounce back to pressed: level never dropped, so no new event.
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LIMIT) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  if (REPEAT_EN) begin : g_repeat
    // Hold counter counts to the last cycle of the current interval and
    // restarts at zero, so it never wraps.
    localparam int unsigned   HW          = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_ONE    = HW'(1);

    logic [HW-1:0] hold_q, hold_d;
    logic          armed_q, armed_d;

    // Hold counter and first-repeat flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_q  <= '0;
        armed_q <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        armed_q <= armed_d;
      end
    end

    // Count while pressed, freeze while release is being qualified.
    always_comb begin
      hold_d   = hold_q;
      armed_d  = armed_q;
      rep_fire = 1'b0;
      case (state_q)
        ST_PRESSED: begin
          if (hold_q == (armed_q ? PERIOD_LAST : DELAY_LAST)) begin
            rep_fire = 1'b1;
            hold_d   = '0;
            armed_d  = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          hold_d  = hold_q;
          armed_d = armed_q;
        end
        default: begin
          hold_d  = '0;
          armed_d = 1'b0;
        end
      endcase
    end
  end else begin : g_no_repeat
    assign rep_fire = 1'b0;
  end

  assign pulse_o = pulse_q;
  assign level_o = level_q;
  assign state_o = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Four-button conditioner (mode, set, op1, op2). Each button gets an
// independent btn_channel. Defining BUTTON_CONDITIONER_AUTOREPEAT_EN
// adds auto-repeat to op1 and op2; mode and set never repeat.
// state_dbg exposes every channel FSM state for observation.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     mode_raw,
  input  logic     set_raw,
  input  logic     op1_raw,
  input  logic     op2_raw,
  output logic     mode_pulse,
  output logic     set_pulse,
  output logic     op1_pulse,
  output logic     op2_pulse,
  output logic     mode_level,
  output logic     set_level,
  output logic     op1_level,
  output logic     op2_level,
  output btn_dbg_t state_dbg
);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam bit OP_REPEAT_EN = 1'b1;
`else
  localparam bit OP_REPEAT_EN = 1'b0;
`endif

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
  ) u_mode (
    .clk_i(clk), .rst_ni(reset), .raw_i(mode_raw),
    .pulse_o(mode_pulse), .level_o(mode_level), .state_o(state_dbg.mode)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
  ) u_set (
    .clk_i(clk), .rst_ni(reset), .raw_i(set_raw),
    .pulse_o(set_pulse), .level_o(set_level), .state_o(state_dbg.set)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(OP_REPEAT_EN)
  ) u_op1 (
    .clk_i(clk), .rst_ni(reset), .raw_i(op1_raw),
    .pulse_o(op1_pulse), .level_o(op1_level), .state_o(state_dbg.op1)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(OP_REPEAT_EN)
  ) u_op2 (
    .clk_i(clk), .rst_ni(reset), .raw_i(op2_raw),
    .pulse_o(op2_pulse), .level_o(op2_level), .state_o(state_dbg.op2)
  );

endmodule
